mskkey_bank_rfrsh: RTL and testbench
====================================

Name: mskkey_bank_rfrsh

Overview:
- Multi-slot masked key store with on-demand sharing refresh.
- Holds NKEYS keys, each a d-share Boolean sharing of Nbits bits, loaded word by word from the FEED_SIZE bus.
- Re-randomises the selected slot's sharing using externally supplied randomness over a valid/ready handshake.
- Sits between the bus input stage / PRNG unit and the masked Clyde core; exposes the selected slot's sharing to the core.

Parameters:
- d, 2, number of shares (>=2)
- Nbits, 128, key bits per share
- FEED_SIZE, 32, bus word width; d*Nbits must be a multiple of FEED_SIZE
- NKEYS, 4, number of key slots (>=1)
- Derived: SEL_W = max(1, clog2(NKEYS)); NWORDS = d*Nbits/FEED_SIZE; CNT_W = max(1, clog2(NWORDS))

Ports:
- clk  in  1  clock, all state on rising edge
- pre_rst_n  in  1  asynchronous active-low reset
- data_in  in  FEED_SIZE  key share word
- data_in_valid  in  1  word valid
- data_in_ready  out  1  high only in LOAD
- load_start  in  1  pulse: begin loading slot load_sel
- load_sel  in  SEL_W  target slot for load
- key_sel  in  SEL_W  slot driven on sharing_key_out and targeted by refresh
- refresh_req  in  1  pulse: refresh slot key_sel
- rnd  in  (d-1)*Nbits  fresh randomness
- rnd_valid  in  1  rnd valid
- rnd_ready  out  1  high only in RFRSH
- sharing_key_out  out  d*Nbits  sharing of slot key_sel; share i at bits [i*Nbits +: Nbits]
- key_out_valid  out  1  slot key_sel valid and not the current load/refresh target
- key_valid  out  NKEYS  per-slot valid flags
- busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous: all slots 0, key_valid 0, state IDLE, word counter 0, latched target 0. All outputs 0 during reset.
- FSM states: IDLE, LOAD, RFRSH.
- IDLE:
  - load_start=1: latch tgt=load_sel, clear key_valid[tgt], counter 0, go to LOAD.
  - Else if refresh_req=1 and key_valid[key_sel]=1: latch tgt=key_sel, go to RFRSH.
  - load_start wins when both are high.
  - refresh_req on an invalid slot is ignored.
- LOAD:
  - Each cycle with data_in_valid=1, write word k (counter value) into slot tgt bits [k*FEED_SIZE +: FEED_SIZE], then increment counter.
  - On the word with k=NWORDS-1: set key_valid[tgt], return to IDLE, counter to 0.
  - No gaps are required; idle cycles simply hold state.
- RFRSH:
  - rnd_ready=1 until the cycle with rnd_valid=1 (inclusive).
  - In that cycle, with r_j = rnd[(j-1)*Nbits +: Nbits]: share_j ^= r_j for j=1..d-1, and share_0 ^= XOR of all r_j.
  - Then return to IDLE. The unmasked key value is unchanged.
- load_start and refresh_req are ignored while busy=1; they are not queued.
- Changing key_sel mid-operation does not move tgt.
- sharing_key_out is a combinational mux of slot registers; it reflects a refresh on the cycle after the handshake.
- key_out_valid = key_valid[key_sel] & ~(busy & tgt==key_sel).
- key_sel or load_sel >= NKEYS (non-power-of-two NKEYS):
  - sharing_key_out = 0 and key_out_valid = 0.
  - Loads to such a slot write nothing; the FSM still consumes NWORDS words.
- Reset mid-LOAD or mid-RFRSH discards everything; all slots return to 0.

Optional Feature:
- Macro: MSKKEY_AUTO_RFRSH_EN.
- Defined: after the last load word the FSM goes directly to RFRSH on tgt instead of IDLE. key_valid[tgt] is set only when that refresh completes, so a freshly loaded sharing is never exposed un-refreshed.
- Undefined: behaviour exactly as above; key_valid[tgt] is set on the last word.

Test Plan:
- Reset/state: assert pre_rst_n=0 mid-LOAD (word 3 of 8) -> all slots 0, key_valid=4'b0000, busy=0 immediately, without a clock edge.
- Load (d=2, Nbits=128, FEED_SIZE=32, NKEYS=4): load_start with load_sel=2, feed 8 words 0x00000001..0x00000008 with 2 idle gaps -> slot 2 = {0x8,0x7,...,0x1} word order, key_valid=4'b0100 on the cycle after word 8; data_in_ready low afterwards.
- Refresh: key_sel=2, refresh_req, rnd_valid delayed 3 cycles with rnd=0xA5..A5 -> share1 ^= 0xA5.., share0 ^= 0xA5..; share0^share1 unchanged; rnd_ready high exactly 4 cycles.
- Ignored requests:
  - refresh_req on invalid slot 1 -> busy stays 0.
  - load_start during RFRSH -> ignored; slot 1 untouched.
- Target masking: refresh slot 2 while key_sel=2 -> key_out_valid=0 during RFRSH, 1 after; key_sel=0 with slot 0 valid -> key_out_valid stays 1 throughout.
- With MSKKEY_AUTO_RFRSH_EN defined: load slot 0 -> rnd_ready rises right after word 8; key_valid[0] is set only after the rnd handshake.

Source files
------------

// File: rtl/mskkey_bank_rfrsh.sv
// NKEYS-slot store of d-share Boolean key sharings, loaded word by word, with sharing refresh.
// Optional macro MSKKEY_AUTO_RFRSH_EN: a freshly loaded slot is refreshed before it is marked valid.
module mskkey_bank_rfrsh #(
    parameter int unsigned d         = 2,
    parameter int unsigned Nbits     = 128,
    parameter int unsigned FEED_SIZE = 32,
    parameter int unsigned NKEYS     = 4,
    parameter int unsigned SEL_W     = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
    input  logic                     clk,
    input  logic                     pre_rst_n,
    input  logic [FEED_SIZE-1:0]     data_in,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    input  logic                     load_start,
    input  logic [SEL_W-1:0]         load_sel,
    input  logic [SEL_W-1:0]         key_sel,
    input  logic                     refresh_req,
    input  logic [(d-1)*Nbits-1:0]   rnd,
    input  logic                     rnd_valid,
    output logic                     rnd_ready,
    output logic [d*Nbits-1:0]       sharing_key_out,
    output logic                     key_out_valid,
    output logic [NKEYS-1:0]         key_valid,
    output logic                     busy
);

    localparam int unsigned KW     = d * Nbits;
    localparam int unsigned NWORDS = KW / FEED_SIZE;
    localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

`ifdef MSKKEY_AUTO_RFRSH_EN
    localparam bit AutoRfrsh = 1'b1;
`else
    localparam bit AutoRfrsh = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StLoad, StRfrsh} state_e;

    state_e             state_q, state_d;
    logic [KW-1:0]      slot_q [NKEYS];
    logic [NKEYS-1:0]   valid_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SEL_W-1:0]   tgt_q;

    logic               sel_valid;
    logic [KW-1:0]      rnd_mask;
    logic               load_go, rfrsh_go, wr_word, rfrsh_done, last_word;

    // Share 0 absorbs the XOR of all masks so the unmasked key is preserved.
    always_comb begin
        rnd_mask = '0;
        for (int j = 1; j < int'(d); j++) begin
            rnd_mask[j*Nbits +: Nbits] = rnd[(j-1)*Nbits +: Nbits];
            rnd_mask[Nbits-1:0]        = rnd_mask[Nbits-1:0] ^ rnd[(j-1)*Nbits +: Nbits];
        end
    end

    // Out-of-range selects match no slot and therefore read as zero / invalid.
    always_comb begin
        sharing_key_out = '0;
        sel_valid       = 1'b0;
        for (int i = 0; i < int'(NKEYS); i++) begin
            if (key_sel == SEL_W'(i)) begin
                sharing_key_out = slot_q[i];
                sel_valid       = valid_q[i];
            end
        end
    end

    assign last_word     = (cnt_q == CNT_W'(NWORDS - 1));
    assign data_in_ready = (state_q == StLoad);
    assign rnd_ready     = (state_q == StRfrsh);
    assign busy          = (state_q != StIdle);
    assign key_valid     = valid_q;
    assign key_out_valid = sel_valid & ~(busy & (tgt_q == key_sel));

    always_comb begin
        state_d    = state_q;
        load_go    = 1'b0;
        rfrsh_go   = 1'b0;
        wr_word    = 1'b0;
        rfrsh_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    load_go = 1'b1;
                    state_d = StLoad;
                end else if (refresh_req && sel_valid) begin
                    rfrsh_go = 1'b1;
                    state_d  = StRfrsh;
                end
            end
            StLoad: begin
                if (data_in_valid) begin
                    wr_word = 1'b1;
                    if (last_word) begin
                        state_d = AutoRfrsh ? StRfrsh : StIdle;
                    end
                end
            end
            StRfrsh: begin
                if (rnd_valid) begin
                    rfrsh_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge pre_rst_n) begin
        if (!pre_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tgt_q   <= '0;
            valid_q <= '0;
            for (int i = 0; i < int'(NKEYS); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (load_go) begin
                tgt_q <= load_sel;
                cnt_q <= '0;
            end
            if (rfrsh_go) begin
                tgt_q <= key_sel;
            end
            if (wr_word) begin
                cnt_q <= last_word ? '0 : cnt_q + 1'b1;
            end
            for (int i = 0; i < int'(NKEYS); i++) begin
                if (load_go && (load_sel == SEL_W'(i))) begin
                    valid_q[i] <= 1'b0;
                end
                if (tgt_q == SEL_W'(i)) begin
                    if (wr_word) begin
                        slot_q[i][cnt_q*FEED_SIZE +: FEED_SIZE] <= data_in;
                        if (last_word && !AutoRfrsh) begin
                            valid_q[i] <= 1'b1;
                        end
                    end
                    if (rfrsh_done) begin
                        slot_q[i] <= slot_q[i] ^ rnd_mask;
                        if (AutoRfrsh) begin
                            valid_q[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mskkey_bank_rfrsh.sv
// Scoreboard bench for mskkey_bank_rfrsh: stimulus queues expectations, a negedge monitor checks them.
module tb_mskkey_bank_rfrsh;

    localparam int KSEL_VALID = 0;
    localparam int KBUSY      = 1;
    localparam int KSHARING   = 2;
    localparam int KKOV       = 3;
    localparam int KDIN_RDY   = 4;
    localparam int KRND_RDY   = 5;
    localparam int KRR_TOTAL  = 6;
    localparam int KUNMASKED  = 7;

    typedef struct {
        string        name;
        int           kind;
        logic [255:0] exp;
    } exp_t;

    logic         clk = 1'b0;
    logic         pre_rst_n;
    logic [31:0]  data_in;
    logic         data_in_valid;
    logic         data_in_ready;
    logic         load_start;
    logic [1:0]   load_sel;
    logic [1:0]   key_sel;
    logic         refresh_req;
    logic [127:0] rnd;
    logic         rnd_valid;
    logic         rnd_ready;
    logic [255:0] sharing_key_out;
    logic         key_out_valid;
    logic [3:0]   key_valid;
    logic         busy;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rr_total = 0;
    int   exp_rr = 0;

    mskkey_bank_rfrsh dut (
        .clk             (clk),
        .pre_rst_n       (pre_rst_n),
        .data_in         (data_in),
        .data_in_valid   (data_in_valid),
        .data_in_ready   (data_in_ready),
        .load_start      (load_start),
        .load_sel        (load_sel),
        .key_sel         (key_sel),
        .refresh_req     (refresh_req),
        .rnd             (rnd),
        .rnd_valid       (rnd_valid),
        .rnd_ready       (rnd_ready),
        .sharing_key_out (sharing_key_out),
        .key_out_valid   (key_out_valid),
        .key_valid       (key_valid),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] obs(input int kind);
        case (kind)
            KSEL_VALID: return {252'b0, key_valid};
            KBUSY:      return {255'b0, busy};
            KSHARING:   return sharing_key_out;
            KKOV:       return {255'b0, key_out_valid};
            KDIN_RDY:   return {255'b0, data_in_ready};
            KRND_RDY:   return {255'b0, rnd_ready};
            KRR_TOTAL:  return 256'(rr_total);
            default:    return {128'b0, sharing_key_out[127:0] ^ sharing_key_out[255:128]};
        endcase
    endfunction

    // Monitor: counts rnd_ready cycles and drains the scoreboard away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        logic [255:0] got;
        if (rnd_ready === 1'b1) rr_total++;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            got = obs(e.kind);
            n_cmp++;
            if (got !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, got, e.exp);
            end
        end
    end

    task automatic push_exp(input string name, input int kind, input logic [255:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = val;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_slot(input logic [1:0] sel, input logic [31:0] base,
                             input logic [3:0] kv_before, output logic [255:0] img);
        logic [3:0] sel_bit;
        sel_bit    = 4'b0001 << sel;
        img        = '0;
        load_sel   = sel;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        push_exp("load_busy", KBUSY, 256'd1);
        push_exp("load_kv_cleared", KSEL_VALID, {252'b0, kv_before & ~sel_bit});
        for (int k = 0; k < 8; k++) begin
            push_exp("load_din_ready", KDIN_RDY, 256'd1);
            data_in       = base + 32'(k);
            data_in_valid = 1'b1;
            img[k*32 +: 32] = base + 32'(k);
            tick();
            data_in_valid = 1'b0;
            if (k == 1 || k == 4) tick();
        end
`ifdef MSKKEY_AUTO_RFRSH_EN
        push_exp("auto_rnd_ready", KRND_RDY, 256'd1);
        push_exp("auto_kv_hidden", KSEL_VALID, {252'b0, kv_before & ~sel_bit});
        rnd       = '0;
        rnd_valid = 1'b1;
        tick();
        rnd_valid = 1'b0;
        exp_rr   += 1;
`endif
        push_exp("load_kv_set", KSEL_VALID, {252'b0, kv_before | sel_bit});
        push_exp("load_din_ready_low", KDIN_RDY, 256'd0);
        push_exp("load_idle", KBUSY, 256'd0);
        push_exp("load_rr_total", KRR_TOTAL, 256'(exp_rr));
    endtask

    logic [255:0] img0, img2, mask;

    initial begin
        pre_rst_n     = 1'b0;
        data_in       = '0;
        data_in_valid = 1'b0;
        load_start    = 1'b0;
        load_sel      = '0;
        key_sel       = 2'd2;
        refresh_req   = 1'b0;
        rnd           = '0;
        rnd_valid     = 1'b0;
        #1;
        push_exp("rst_key_valid", KSEL_VALID, 256'd0);
        push_exp("rst_busy", KBUSY, 256'd0);
        push_exp("rst_sharing", KSHARING, 256'd0);
        push_exp("rst_din_ready", KDIN_RDY, 256'd0);
        push_exp("rst_rnd_ready", KRND_RDY, 256'd0);
        repeat (2) @(posedge clk);
        #1;
        pre_rst_n = 1'b1;
        tick();

        // Load slot 2 with words 1..8 (two idle gaps).
        key_sel = 2'd2;
        load_slot(2'd2, 32'd1, 4'b0000, img2);
        push_exp("slot2_image", KSHARING,
                 {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        push_exp("slot2_kov", KKOV, 256'd1);
        tick();

        // Refresh on an invalid slot is dropped.
        key_sel     = 2'd1;
        refresh_req = 1'b1;
        tick();
        refresh_req = 1'b0;
        push_exp("inval_rfrsh_busy", KBUSY, 256'd0);
        push_exp("inval_rfrsh_rnd_ready", KRND_RDY, 256'd0);
        push_exp("inval_kov", KKOV, 256'd0);
        tick();

        key_sel = 2'd0;
        load_slot(2'd0, 32'h0000_0100, 4'b0100, img0);
        tick();

        // Refresh slot 2, rnd arriving on the fourth RFRSH cycle.
        key_sel     = 2'd2;
        refresh_req = 1'b1;
        tick();
        refresh_req = 1'b0;
        push_exp("rfrsh_busy", KBUSY, 256'd1);
        push_exp("rfrsh_rnd_ready", KRND_RDY, 256'd1);
        push_exp("rfrsh_kov_tgt", KKOV, 256'd0);
        tick();
        load_start = 1'b1;
        load_sel   = 2'd1;
        key_sel    = 2'd0;
        push_exp("rfrsh_kov_other", KKOV, 256'd1);
        push_exp("rfrsh_mux_other", KSHARING, img0);
        tick();
        load_start = 1'b0;
        key_sel    = 2'd2;
        push_exp("rfrsh_kov_tgt2", KKOV, 256'd0);
        push_exp("rfrsh_tgt_kept", KRND_RDY, 256'd1);
        tick();
        rnd       = {16{8'hA5}};
        rnd_valid = 1'b1;
        push_exp("rfrsh_rnd_ready_c4", KRND_RDY, 256'd1);
        tick();
        rnd_valid = 1'b0;
        exp_rr   += 4;
        mask      = {rnd, rnd};
        push_exp("rfrsh_sharing", KSHARING, img2 ^ mask);
        push_exp("rfrsh_unmasked", KUNMASKED, {128'b0, img2[127:0] ^ img2[255:128]});
        push_exp("rfrsh_kov_after", KKOV, 256'd1);
        push_exp("rfrsh_idle", KBUSY, 256'd0);
        push_exp("rfrsh_key_valid", KSEL_VALID, 256'b0101);
        push_exp("rfrsh_rr_total", KRR_TOTAL, 256'(exp_rr));
        tick();
        key_sel = 2'd1;
        push_exp("slot1_untouched", KSHARING, 256'd0);
        push_exp("slot1_kov", KKOV, 256'd0);
        tick();

        // Reset while loading slot 3, during word 3.
        load_sel   = 2'd3;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            data_in       = 32'(k);
            data_in_valid = 1'b1;
            if (k < 3) tick();
        end
        #1;
        pre_rst_n = 1'b0;
        key_sel   = 2'd2;
        #1;
        n_cmp++;
        if (key_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL midrst_async_key_valid: got %b want %b", key_valid, 4'b0000);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_async_busy: got %b want %b", busy, 1'b0);
        end
        n_cmp++;
        if (data_in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_async_din_ready: got %b want %b", data_in_ready, 1'b0);
        end
        n_cmp++;
        if (sharing_key_out !== 256'd0) begin
            n_bad++;
            $display("FAIL midrst_async_slot2: got %h want %h", sharing_key_out, 256'd0);
        end
        push_exp("midrst_key_valid", KSEL_VALID, 256'd0);
        push_exp("midrst_busy", KBUSY, 256'd0);
        push_exp("midrst_slot2", KSHARING, 256'd0);
        push_exp("midrst_din_ready", KDIN_RDY, 256'd0);
        tick();
        data_in_valid = 1'b0;
        pre_rst_n     = 1'b1;
        tick();
        key_sel = 2'd0;
        push_exp("post_rst_slot0", KSHARING, 256'd0);
        push_exp("post_rst_idle", KBUSY, 256'd0);
        repeat (2) tick();

        if (n_bad != 0) begin
            $display("FAIL summary: got %0d mismatches want 0", n_bad);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
